// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory round-robin arbiter: FSM encodings,
// default bus widths and the index-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FREE  = 2'd3
  } arb_state_e;

  localparam int DEF_AW = 10;
  localparam int DEF_DW = 32;

  // Ceiling log2, never less than 1 so that index vectors always have a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((32'sd1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set bit of the
// pending vector at or after the pointer, wrapping modulo N_REQ.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PW    = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [PW-1:0]    ptr_i,
  output logic             found_o,
  output logic [PW-1:0]    idx_o
);

  // Scan from the pointer onward; the first hit wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(ptr_i) + k) % N_REQ;
      if (!found_o && pending_i[j]) begin
        found_o = 1'b1;
        idx_o   = PW'(j);
      end else begin
        found_o = found_o;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// N-way round-robin arbiter sharing one memory port using drive/free
// handshakes. Each requester pulses i_drive and later receives one o_free
// pulse once the memory acknowledged its access with i_mem_done.
// Optional build macro MEM_ARB_TIMEOUT_EN adds a WAIT-state watchdog of
// TIMEOUT_CYC cycles; without it o_timeout is tied low.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int AW          = DEF_AW,
  parameter int DW          = DEF_DW,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    i_drive,
  input  logic [N_REQ-1:0]    i_we,
  input  logic [N_REQ*AW-1:0] i_addr,
  input  logic [N_REQ*DW-1:0] i_wdata,
  output logic [N_REQ-1:0]    o_free,
  output logic [DW-1:0]       o_rdata,
  output logic [N_REQ-1:0]    o_overrun,
  output logic                o_busy,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [AW-1:0]       o_mem_addr,
  output logic [DW-1:0]       o_mem_wdata,
  input  logic                i_mem_done,
  input  logic [DW-1:0]       i_mem_rdata,
  output logic                o_timeout
);

  localparam int PW = clog2(N_REQ);

  // Elaboration-time guard against unsupported configurations.
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 1) begin : g_param_err
    $error("mem_rr_arbiter: unsupported parameter set");
  end

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  pend_q, pend_d;
  logic [N_REQ-1:0]  ovr_q, ovr_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     idx_q, idx_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic              grant_s;
  logic              pick_found_s;
  logic [PW-1:0]     pick_idx_s;
  logic [N_REQ-1:0]  free_s;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          expire_s;

  assign expire_s = (cnt_q == CW'(TIMEOUT_CYC - 1));
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_pick (
    .pending_i (pend_q),
    .ptr_i     (ptr_q),
    .found_o   (pick_found_s),
    .idx_o     (pick_idx_s)
  );

  // Next-state logic of the access FSM and its latched access bundle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    grant_s = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          grant_s = 1'b1;
          idx_d   = pick_idx_s;
          we_d    = i_we[pick_idx_s];
          addr_d  = i_addr[pick_idx_s*AW +: AW];
          wdata_d = i_wdata[pick_idx_s*DW +: DW];
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        // A done in this cycle cannot belong to this access and is ignored.
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A done coinciding with watchdog expiry is a normal completion.
        if (i_mem_done) begin
          rdata_d = i_mem_rdata;
          state_d = ST_FREE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (expire_s) begin
          rdata_d = '0;
          tmo_d   = 1'b1;
          state_d = ST_FREE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_WAIT;
        end
`else
        else begin
          state_d = ST_WAIT;
        end
`endif
      end
      ST_FREE: begin
        ptr_d   = (idx_q == PW'(N_REQ - 1)) ? '0 : idx_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pending/overrun capture: a drive for a requester that is already queued
  // or in service is flagged instead of queued; its FREE cycle is legal.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (grant_s) begin
      pend_d[pick_idx_s] = 1'b0;
    end else begin
      pend_d = pend_q;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (i_drive[i]) begin
        if (pend_q[i] ||
            (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (idx_q == PW'(i)))) begin
          ovr_d[i] = 1'b1;
        end else begin
          pend_d[i] = 1'b1;
        end
      end else begin
        ovr_d[i] = ovr_d[i];
      end
    end
  end

  // Decode the one-hot completion pulse of the requester in service.
  always_comb begin
    free_s = '0;
    if (state_q == ST_FREE) begin
      free_s[idx_q] = 1'b1;
    end else begin
      free_s = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      ovr_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  // Watchdog counter and timeout pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_free      = free_s;
  assign o_rdata     = rdata_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_mem_en    = (state_q == ST_ISSUE);
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Directed self-checking bench for mem_rr_arbiter (N_REQ=2, TIMEOUT_CYC=8).
// Cycle n is the interval after the n-th observed rising edge; inputs are
// driven and outputs sampled 1 time unit after that edge.
module tb_mem_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 10;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    i_drive;
  logic [N-1:0]    i_we;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    o_free;
  logic [DW-1:0]   o_rdata;
  logic [N-1:0]    o_overrun;
  logic            o_busy;
  logic            o_mem_en;
  logic            o_mem_we;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_mem_wdata;
  logic            i_mem_done;
  logic [DW-1:0]   i_mem_rdata;
  logic            o_timeout;

  int checks = 0;
  int errors = 0;

  mem_rr_arbiter #(
    .N_REQ       (N),
    .AW          (AW),
    .DW          (DW),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_drive     (i_drive),
    .i_we        (i_we),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_free      (o_free),
    .o_rdata     (o_rdata),
    .o_overrun   (o_overrun),
    .o_busy      (o_busy),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_done  (i_mem_done),
    .i_mem_rdata (i_mem_rdata),
    .o_timeout   (o_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_drive = '0;
    i_mem_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (o_free !== 2'b00) begin errors++; $display("FAIL reset_free got %b want 00", o_free); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b want 0", o_mem_en); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rdata); end
    checks++; if (o_overrun !== 2'b00) begin errors++; $display("FAIL reset_overrun got %b want 00", o_overrun); end
    checks++; if (o_mem_addr !== 10'h0) begin errors++; $display("FAIL reset_addr got %h want 0", o_mem_addr); end
    checks++; if (o_timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b want 0", o_timeout); end
    rst = 1'b0;
  endtask

  task automatic test_single_read();
    do_reset();
    // cycle 0
    i_drive = 2'b01; i_we = 2'b00; i_addr[9:0] = 10'h012;
    tick(); i_drive = 2'b00;                       // cycle 1
    checks++; if (o_mem_en !== 1'b0) begin errors++; $display("FAIL single_en_c1 got %b want 0", o_mem_en); end
    tick();                                        // cycle 2
    checks++; if (o_mem_en !== 1'b1) begin errors++; $display("FAIL single_en_c2 got %b want 1", o_mem_en); end
    checks++; if (o_mem_addr !== 10'h012) begin errors++; $display("FAIL single_addr got %h want 012", o_mem_addr); end
    checks++; if (o_mem_we !== 1'b0) begin errors++; $display("FAIL single_we got %b want 0", o_mem_we); end
    tick();                                        // cycle 3
    checks++; if (o_mem_en !== 1'b0 || o_busy !== 1'b1) begin errors++; $display("FAIL single_wait en=%b busy=%b want 0 1", o_mem_en, o_busy); end
    tick(); tick();                                // cycle 5
    i_mem_done = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    checks++; if (o_free !== 2'b00) begin errors++; $display("FAIL single_free_c5 got %b want 00", o_free); end
    tick(); i_mem_done = 1'b0;                     // cycle 6
    checks++; if (o_free !== 2'b01) begin errors++; $display("FAIL single_free_c6 got %b want 01", o_free); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h want deadbeef", o_rdata); end
    tick();                                        // cycle 7
    checks++; if (o_free !== 2'b00 || o_busy !== 1'b0) begin errors++; $display("FAIL single_end free=%b busy=%b want 00 0", o_free, o_busy); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata_hold got %h want deadbeef", o_rdata); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    // cycle 0
    i_drive = 2'b11; i_we = 2'b10;
    i_addr = {10'h200, 10'h100}; i_wdata = {32'hCAFE0001, 32'h0};
    tick(); i_drive = 2'b00;                       // cycle 1
    tick();                                        // cycle 2
    checks++; if (o_mem_en !== 1'b1 || o_mem_addr !== 10'h100) begin errors++; $display("FAIL simul_req0 en=%b addr=%h want 1 100", o_mem_en, o_mem_addr); end
    tick(); i_mem_done = 1'b1; i_mem_rdata = 32'h11111111;   // cycle 3
    tick(); i_mem_done = 1'b0;                     // cycle 4
    checks++; if (o_free !== 2'b01) begin errors++; $display("FAIL simul_free0 got %b want 01", o_free); end
    tick();                                        // cycle 5
    checks++; if (o_mem_en !== 1'b0 || o_free !== 2'b00) begin errors++; $display("FAIL simul_gap en=%b free=%b want 0 00", o_mem_en, o_free); end
    tick();                                        // cycle 6
    checks++; if (o_mem_en !== 1'b1 || o_mem_addr !== 10'h200) begin errors++; $display("FAIL simul_req1 en=%b addr=%h want 1 200", o_mem_en, o_mem_addr); end
    checks++; if (o_mem_we !== 1'b1 || o_mem_wdata !== 32'hCAFE0001) begin errors++; $display("FAIL simul_wr we=%b wdata=%h want 1 cafe0001", o_mem_we, o_mem_wdata); end
    tick(); i_mem_done = 1'b1; i_mem_rdata = 32'h22222222;   // cycle 7
    tick(); i_mem_done = 1'b0;                     // cycle 8
    checks++; if (o_free !== 2'b10) begin errors++; $display("FAIL simul_free1 got %b want 10", o_free); end
    checks++; if (o_rdata !== 32'h22222222) begin errors++; $display("FAIL simul_rdata got %h want 22222222", o_rdata); end
    checks++; if (o_overrun !== 2'b00) begin errors++; $display("FAIL simul_overrun got %b want 00", o_overrun); end
    tick();
  endtask

  task automatic test_fairness();
    logic [N-1:0] want_free;
    logic [AW-1:0] want_addr;
    int t;
    do_reset();
    i_we = 2'b00; i_addr = {10'h0B1, 10'h0A0};
    i_drive = 2'b11;
    tick(); i_drive = 2'b00;
    for (int g = 0; g < 20; g++) begin
      want_free = (g % 2 == 0) ? 2'b01 : 2'b10;
      want_addr = (g % 2 == 0) ? 10'h0A0 : 10'h0B1;
      t = 0;
      while (o_mem_en !== 1'b1 && t < 8) begin tick(); t++; end
      checks++; if (o_mem_en !== 1'b1 || o_mem_addr !== want_addr) begin errors++; $display("FAIL fair_grant%0d en=%b addr=%h want 1 %h", g, o_mem_en, o_mem_addr, want_addr); end
      tick(); i_mem_done = 1'b1; i_mem_rdata = g;
      tick(); i_mem_done = 1'b0;
      checks++; if (o_free !== want_free) begin errors++; $display("FAIL fair_free%0d got %b want %b", g, o_free, want_free); end
      if (g + 2 < 20) i_drive = want_free;
      tick(); i_drive = 2'b00;
    end
    checks++; if (o_overrun !== 2'b00) begin errors++; $display("FAIL fair_overrun got %b want 00", o_overrun); end
    tick();
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL fair_idle busy=%b want 0", o_busy); end
  endtask

  task automatic test_overrun();
    int ens;
    do_reset();
    i_we = 2'b00; i_addr[19:10] = 10'h155;
    i_drive = 2'b10;                               // cycle 0
    tick();                                        // cycle 1: second drive
    tick(); i_drive = 2'b00;                       // cycle 2
    checks++; if (o_mem_en !== 1'b1 || o_mem_addr !== 10'h155) begin errors++; $display("FAIL ovr_issue en=%b addr=%h want 1 155", o_mem_en, o_mem_addr); end
    checks++; if (o_overrun !== 2'b10) begin errors++; $display("FAIL ovr_flag got %b want 10", o_overrun); end
    tick(); i_mem_done = 1'b1; i_mem_rdata = 32'h0;          // cycle 3
    tick(); i_mem_done = 1'b0;                     // cycle 4
    checks++; if (o_free !== 2'b10) begin errors++; $display("FAIL ovr_free got %b want 10", o_free); end
    ens = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (o_mem_en === 1'b1) ens++; end
    checks++; if (ens !== 0) begin errors++; $display("FAIL ovr_extra_access got %0d want 0", ens); end
    checks++; if (o_overrun !== 2'b10) begin errors++; $display("FAIL ovr_sticky got %b want 10", o_overrun); end
    do_reset();
    checks++; if (o_overrun !== 2'b00) begin errors++; $display("FAIL ovr_cleared got %b want 00", o_overrun); end
  endtask

  task automatic test_reset_mid_wait();
    int frees;
    do_reset();
    i_we = 2'b00; i_addr[9:0] = 10'h3C3;
    i_drive = 2'b01;                               // cycle 0
    tick(); i_drive = 2'b00;                       // cycle 1
    tick();                                        // cycle 2
    tick(); rst = 1'b1;                            // cycle 3 (WAIT)
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL rstw_in_wait busy=%b want 1", o_busy); end
    tick(); rst = 1'b0;                            // cycle 4
    i_mem_done = 1'b1; i_mem_rdata = 32'h55555555;
    checks++; if (o_busy !== 1'b0 || o_mem_en !== 1'b0 || o_free !== 2'b00) begin errors++; $display("FAIL rstw_after busy=%b en=%b free=%b want 0 0 00", o_busy, o_mem_en, o_free); end
    tick(); i_mem_done = 1'b0;
    frees = 0;
    for (int c = 0; c < 4; c++) begin if (o_free !== 2'b00) frees++; tick(); end
    checks++; if (frees !== 0) begin errors++; $display("FAIL rstw_no_free got %0d free cycles want 0", frees); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL rstw_rdata got %h want 0", o_rdata); end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    i_we = 2'b00; i_addr[9:0] = 10'h044;
    // A normal read first so a forced zero in o_rdata is observable.
    i_drive = 2'b01; tick(); i_drive = 2'b00; tick();
    tick(); i_mem_done = 1'b1; i_mem_rdata = 32'hA5A5A5A5;
    tick(); i_mem_done = 1'b0;
    checks++; if (o_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL tmo_pre_rdata got %h want a5a5a5a5", o_rdata); end
    tick();
    i_drive = 2'b01;                               // cycle 0
    tick(); i_drive = 2'b00;                       // cycle 1
    tick();                                        // cycle 2 ISSUE
    bad = 0;
    for (int c = 3; c < 11; c++) begin
      tick();                                      // cycles 3..10
      if (o_free !== 2'b00 || o_timeout !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL tmo_early got %0d early pulses want 0", bad); end
`ifdef MEM_ARB_TIMEOUT_EN
    tick();                                        // cycle 11
    checks++; if (o_free !== 2'b01 || o_timeout !== 1'b1) begin errors++; $display("FAIL tmo_pulse free=%b tmo=%b want 01 1", o_free, o_timeout); end
    checks++; if (o_rdata !== 32'h0) begin errors++; $display("FAIL tmo_rdata got %h want 0", o_rdata); end
    tick();
    checks++; if (o_timeout !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL tmo_after tmo=%b busy=%b want 0 0", o_timeout, o_busy); end
`else
    tick();                                        // cycle 11: still waiting
    checks++; if (o_busy !== 1'b1 || o_free !== 2'b00 || o_timeout !== 1'b0) begin errors++; $display("FAIL notmo_wait busy=%b free=%b tmo=%b want 1 00 0", o_busy, o_free, o_timeout); end
    i_mem_done = 1'b1; i_mem_rdata = 32'h0000BEEF;
    tick(); i_mem_done = 1'b0;
    checks++; if (o_free !== 2'b01 || o_rdata !== 32'h0000BEEF) begin errors++; $display("FAIL notmo_done free=%b rdata=%h want 01 0000beef", o_free, o_rdata); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    i_drive = '0; i_we = '0; i_addr = '0; i_wdata = '0;
    i_mem_done = 1'b0; i_mem_rdata = '0;
    test_reset();
    test_single_read();
    test_simultaneous();
    test_fairness();
    test_overrun();
    test_reset_mid_wait();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
